lr_ram_sched: RTL
=================

# lr_ram_sched

Scheduler and port arbiter for the single-port data-point RAM shared by the host loader and the LR trainer core. It owns the RAM address and control lines and grants the port to the host while idle or done, and to the trainer while training. During training it streams the weight row (row 0) and then data rows 1..DPS once per epoch, counts epochs, and commits the trainer's final weights back to row 0.

## Interface
- MAX_FEATURES, 6, features per row; row width ROW_W = (MAX_FEATURES+1)*16
- DP_BITS, 4, RAM address width
- DPS, 6, data points per epoch; legal range 1..2^DP_BITS-1
- TOTAL_EPOCHS, 15, epochs to run; legal range 1..63
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins training; honoured only in IDLE or DONE
- host_req / host_we  in  1 / 1  host access request; write when host_we=1
- host_addr  in  DP_BITS  host row address
- host_wdata  in  ROW_W  host write data
- host_gnt  out  1  combinational; the request is accepted when host_req && host_gnt
- host_rvalid / host_rdata  out  1 / ROW_W  host read return
- tr_req  in  1  trainer requests the next row
- tr_gnt  out  1  combinational; the request is accepted when tr_req && tr_gnt
- tr_rvalid / tr_rdata  out  1 / ROW_W  trainer read return
- tr_idx  out  DP_BITS  row index of the last accepted trainer read
- tr_fin  out  1  epochs exhausted; trainer must write back its weights
- tr_wb / tr_wdata  in  1 / ROW_W  weight write-back, packed {wt0..wt6}
- epoch  out  6  completed epochs
- busy / done  out  1 / 1  training in progress / weights committed (sticky)
- ram_addr / ram_we / ram_oe / ram_wdata  out  DP_BITS / 1 / 1 / ROW_W  registered RAM controls
- ram_rdata  in  ROW_W  RAM read data, valid one cycle after ram_oe

## Operation
- States: IDLE, LDWT, RUN, FIN, DONE.
- **IDLE / DONE (host owns the port).**
  - host_gnt = !pending && !start.
  - On `start`, the FSM clears epoch and done, sets idx=1, and goes to LDWT.
  - `start` outside IDLE/DONE is ignored.
- **LDWT.** The block issues an internal read of row 0, delivered on tr_rvalid with tr_idx=0, then goes to RUN without a trainer request.
- **RUN (trainer owns the port).**
  - tr_gnt = !pending.
  - Each accepted tr_req reads row idx and drives tr_idx=idx.
  - If idx==DPS: idx←1 and epoch←epoch+1. Otherwise idx←idx+1.
  - When the incremented epoch equals TOTAL_EPOCHS, the FSM goes to FIN after that read returns.
- **FIN.**
  - tr_fin=1 and tr_gnt=0.
  - tr_wb is accepted on the first cycle it is high: ram_we writes tr_wdata to row 0, then the FSM goes to DONE with done=1.
- Only one read is outstanding at a time; `pending` is set at acceptance and cleared at rvalid.
- Requests made while not granted are not queued; the requester holds them.
- host_req outside IDLE/DONE is stalled with host_gnt=0 and is never dropped silently.
- busy = (state is LDWT, RUN or FIN).
- Epoch arithmetic is unsigned 6-bit. The epoch counter saturates at TOTAL_EPOCHS.

## Timing
- Reset (RST_N low at an edge): state=IDLE, all registered outputs 0, epoch=0, idx=1, pending=0, done=0.
- RAM contents are untouched by reset.
- Reset mid-operation abandons any in-flight read; no rvalid follows it.
- Read latency: acceptance in cycle N → ram_addr/ram_oe valid in N+1 → rvalid and rdata (pass-through of ram_rdata) in N+2.
- The next acceptance can occur no earlier than N+2, the same cycle as rvalid.
- Write: acceptance in cycle N → ram_we/ram_addr/ram_wdata asserted for exactly one cycle in N+1. Writes produce no rvalid.
- LDWT: row 0 is on tr_rdata 2 cycles after the start pulse.
- start and host_req in the same cycle: start wins and the host is not granted.
- FIN → DONE: done rises 2 cycles after tr_wb is accepted, when the write completes.

## Test plan
- **Reset:** hold RST_N=0 for 3 cycles with random inputs → all outputs 0, ram_we never 1; release → IDLE, host_gnt=1.
- **Host load and readback:** write rows 0..6 (row k = k replicated), read row 3 → host_rvalid 2 cycles after acceptance with data 3.
- **Full run, DPS=6, TOTAL_EPOCHS=2:** pulse start, trainer requests whenever granted.
  - tr_idx sequence is 0,1..6,1..6.
  - epoch steps 0→1→2.
  - tr_fin asserts after the 12th data row.
  - tr_wb=0xABCD… → row 0 is rewritten and done=1.
- **Contention:** host_req held during RUN → host_gnt stays 0 until DONE, then it is serviced; start together with host_req in IDLE → training starts and the host is not granted.
- **Back-to-back:** tr_req held high → one acceptance every 2 cycles, never two outstanding.
- **Mid-run reset:** assert RST_N=0 during the 2nd epoch → IDLE, epoch=0, no stray rvalid, row 0 unchanged.

Source files
------------

// File: rtl/lr_ram_sched_if.sv
// Bundle of host, trainer and RAM-side signals around the data-point RAM scheduler.
// The scheduler connects through the slave modport; the surrounding system uses master.
interface lr_ram_sched_if #(
    parameter int MAX_FEATURES = 6,
    parameter int DP_BITS      = 4
);
    localparam int ROW_W = (MAX_FEATURES + 1) * 16;

    logic               start;
    logic               host_req;
    logic               host_we;
    logic [DP_BITS-1:0] host_addr;
    logic [ROW_W-1:0]   host_wdata;
    logic               host_gnt;
    logic               host_rvalid;
    logic [ROW_W-1:0]   host_rdata;
    logic               tr_req;
    logic               tr_gnt;
    logic               tr_rvalid;
    logic [ROW_W-1:0]   tr_rdata;
    logic [DP_BITS-1:0] tr_idx;
    logic               tr_fin;
    logic               tr_wb;
    logic [ROW_W-1:0]   tr_wdata;
    logic [5:0]         epoch;
    logic               busy;
    logic               done;
    logic [DP_BITS-1:0] ram_addr;
    logic               ram_we;
    logic               ram_oe;
    logic [ROW_W-1:0]   ram_wdata;
    logic [ROW_W-1:0]   ram_rdata;

    modport slave (
        input  start, host_req, host_we, host_addr, host_wdata,
        input  tr_req, tr_wb, tr_wdata, ram_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output tr_gnt, tr_rvalid, tr_rdata, tr_idx, tr_fin,
        output epoch, busy, done,
        output ram_addr, ram_we, ram_oe, ram_wdata
    );

    modport master (
        output start, host_req, host_we, host_addr, host_wdata,
        output tr_req, tr_wb, tr_wdata, ram_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  tr_gnt, tr_rvalid, tr_rdata, tr_idx, tr_fin,
        input  epoch, busy, done,
        input  ram_addr, ram_we, ram_oe, ram_wdata
    );
endinterface

// File: rtl/lr_ram_sched.sv
// Single-port data-point RAM arbiter: host owns the port when idle/done, the LR trainer
// while training; streams weight row then data rows each epoch and commits final weights.
module lr_ram_sched #(
    parameter int MAX_FEATURES = 6,
    parameter int DP_BITS      = 4,
    parameter int DPS          = 6,
    parameter int TOTAL_EPOCHS = 15
) (
    input logic          CLK,
    input logic          RST_N,
    lr_ram_sched_if.slave bus
);
    localparam int ROW_W = (MAX_FEATURES + 1) * 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDWT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state;
    logic [5:0]         epoch_q;
    logic [DP_BITS-1:0] idx;
    logic [DP_BITS-1:0] tr_idx_q;
    logic [DP_BITS-1:0] ram_addr_q;
    logic               ram_we_q;
    logic               ram_oe_q;
    logic [ROW_W-1:0]   ram_wdata_q;
    logic               rd_tr_p1;
    logic               rv_host_p2;
    logic               rv_tr_p2;
    logic               last_rd;
    logic               wb_p1;
    logic               done_q;

    logic               host_owns;
    logic               pending;
    logic               host_gnt;
    logic               tr_gnt;
    logic               host_acc;
    logic               tr_acc;
    logic               wb_acc;
    logic [5:0]         ep_inc;

    function automatic logic [5:0] sat_epoch_inc(input logic [5:0] e);
        if (e >= 6'(TOTAL_EPOCHS))
            return 6'(TOTAL_EPOCHS);
        else
            return e + 6'd1;
    endfunction

    // A read occupies the port only while its address is on the RAM; the cycle it
    // returns is already free for the next acceptance.
    assign host_owns = (state == S_IDLE) || (state == S_DONE);
    assign pending   = ram_oe_q;
    assign host_gnt  = RST_N && host_owns && !pending && !bus.start;
    assign tr_gnt    = RST_N && (state == S_RUN) && !pending && !last_rd;
    assign host_acc  = bus.host_req && host_gnt;
    assign tr_acc    = bus.tr_req && tr_gnt;
    assign wb_acc    = bus.tr_wb && (state == S_FIN) && !wb_p1;
    assign ep_inc    = sat_epoch_inc(epoch_q);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            epoch_q     <= 6'd0;
            idx         <= DP_BITS'(1);
            tr_idx_q    <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_tr_p1    <= 1'b0;
            rv_host_p2  <= 1'b0;
            rv_tr_p2    <= 1'b0;
            last_rd     <= 1'b0;
            wb_p1       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // p1: RAM control stage -> p2: read data returns to its owner
            ram_we_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            rd_tr_p1   <= 1'b0;
            wb_p1      <= 1'b0;
            rv_host_p2 <= ram_oe_q && !rd_tr_p1;
            rv_tr_p2   <= ram_oe_q && rd_tr_p1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        epoch_q    <= 6'd0;
                        done_q     <= 1'b0;
                        idx        <= DP_BITS'(1);
                        ram_addr_q <= '0;
                        ram_oe_q   <= 1'b1;
                        rd_tr_p1   <= 1'b1;
                        tr_idx_q   <= '0;
                        state      <= S_LDWT;
                    end else if (host_acc) begin
                        ram_addr_q <= bus.host_addr;
                        if (bus.host_we) begin
                            ram_we_q    <= 1'b1;
                            ram_wdata_q <= bus.host_wdata;
                        end else begin
                            ram_oe_q <= 1'b1;
                        end
                    end
                end
                S_LDWT: state <= S_RUN;
                S_RUN: begin
                    if (tr_acc) begin
                        ram_addr_q <= idx;
                        ram_oe_q   <= 1'b1;
                        rd_tr_p1   <= 1'b1;
                        tr_idx_q   <= idx;
                        if (idx == DP_BITS'(DPS)) begin
                            idx     <= DP_BITS'(1);
                            epoch_q <= ep_inc;
                            if (ep_inc == 6'(TOTAL_EPOCHS))
                                last_rd <= 1'b1;
                        end else begin
                            idx <= idx + DP_BITS'(1);
                        end
                    end
                    // Leave only once the final data row has been handed over.
                    if (rv_tr_p2 && last_rd) begin
                        last_rd <= 1'b0;
                        state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (wb_acc) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= bus.tr_wdata;
                        wb_p1       <= 1'b1;
                    end
                    if (wb_p1) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.host_gnt    = host_gnt;
    assign bus.tr_gnt      = tr_gnt;
    assign bus.host_rvalid = rv_host_p2;
    assign bus.host_rdata  = rv_host_p2 ? bus.ram_rdata : '0;
    assign bus.tr_rvalid   = rv_tr_p2;
    assign bus.tr_rdata    = rv_tr_p2 ? bus.ram_rdata : '0;
    assign bus.tr_idx      = tr_idx_q;
    assign bus.tr_fin      = (state == S_FIN);
    assign bus.epoch       = epoch_q;
    assign bus.busy        = (state == S_LDWT) || (state == S_RUN) || (state == S_FIN);
    assign bus.done        = done_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_oe      = ram_oe_q;
    assign bus.ram_wdata   = ram_wdata_q;
endmodule
